// File: rtl/clock_controller.sv
// CPU clock sequencer: continuous run, single micro-step and whole-instruction
// step from sys_clk, with a debounced step button and sticky halt handling.
module clock_controller #(
    parameter int HALF_PERIOD = 4,
    parameter int DEBOUNCE    = 16,
    parameter int STEPS       = 5
) (
    input  logic                     sys_clk,
    input  logic                     rst,
    input  logic                     mode,
    input  logic                     instr_step,
    input  logic                     step_btn,
    input  logic                     halt,
    output logic                     cpu_clk,
    output logic                     clk_rise,
    output logic [$clog2(STEPS)-1:0] micro,
    output logic                     halted,
    output logic                     busy
);
    localparam int TW = $clog2(HALF_PERIOD) + 1;
    localparam int DW = $clog2(DEBOUNCE) + 1;
    localparam int MW = $clog2(STEPS);
    localparam logic [TW-1:0] T_RELOAD = TW'(HALF_PERIOD - 1);
    localparam logic [DW-1:0] D_LAST   = DW'(DEBOUNCE - 1);
    localparam logic [MW-1:0] M_LAST   = MW'(STEPS - 1);

    typedef enum logic [2:0] {STOP, RUN_HI, RUN_LO, STEP_HI, STEP_LO} state_t;

    state_t        state;
    state_t        state_nx;
    logic [TW-1:0] timer;
    logic          halt_pend;
    logic          halt_now;
    logic          timer_done;
    logic          entering;
    logic          enter_hi;

    logic          btn_p0;
    logic          btn_p1;
    logic          btn_level;
    logic          step_req;
    logic [DW-1:0] db_cnt;

    // Stage p0/p1: two-flop synchroniser, then debounce on the p1 sample
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            btn_p0    <= 1'b0;
            btn_p1    <= 1'b0;
            btn_level <= 1'b0;
            db_cnt    <= '0;
            step_req  <= 1'b0;
        end else begin
            btn_p0   <= step_btn;
            btn_p1   <= btn_p0;
            step_req <= 1'b0;
            if (btn_p1 == btn_level) begin
                db_cnt <= '0;
            end else if (db_cnt == D_LAST) begin
                db_cnt    <= '0;
                btn_level <= btn_p1;
                step_req  <= btn_p1;
            end else begin
                db_cnt <= db_cnt + DW'(1);
            end
        end
    end

    // A halt arriving in the very last low cycle still stops this pulse.
    assign halt_now   = halt_pend | halt;
    assign timer_done = (timer == '0);

    always_comb begin
        state_nx = state;
        case (state)
            STOP: begin
                if (!halted) begin
                    if (!mode)
                        state_nx = RUN_HI;
                    else if (step_req)
                        state_nx = STEP_HI;
                end
            end
            RUN_HI:  if (timer_done) state_nx = RUN_LO;
            RUN_LO:  if (timer_done) state_nx = (halt_now || mode) ? STOP : RUN_HI;
            STEP_HI: if (timer_done) state_nx = STEP_LO;
            STEP_LO: begin
                if (timer_done) begin
                    if (!halt_now && instr_step && (micro != '0))
                        state_nx = STEP_HI;
                    else
                        state_nx = STOP;
                end
            end
            default: state_nx = STOP;
        endcase
    end

    assign entering = (state_nx != state);
    assign enter_hi = entering && (state_nx == RUN_HI || state_nx == STEP_HI);

    // Every output is registered from the next state, so cpu_clk cannot glitch.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state     <= STOP;
            timer     <= '0;
            micro     <= '0;
            cpu_clk   <= 1'b0;
            clk_rise  <= 1'b0;
            halted    <= 1'b0;
            busy      <= 1'b0;
            halt_pend <= 1'b0;
        end else begin
            state    <= state_nx;
            clk_rise <= enter_hi;
            cpu_clk  <= (state_nx == RUN_HI) || (state_nx == STEP_HI);
            busy     <= (state_nx != STOP);
            if (halt)
                halt_pend <= 1'b1;
            if (entering) begin
                timer <= (state_nx == STOP) ? '0 : T_RELOAD;
                if (state_nx == STOP && halt_now)
                    halted <= 1'b1;
            end else if (!timer_done) begin
                timer <= timer - TW'(1);
            end
            if (enter_hi)
                micro <= (micro == M_LAST) ? '0 : micro + MW'(1);
        end
    end

endmodule

// File: doc/clock_controller.md
# clock_controller

Sequencer for the CPU clock. Generates `cpu_clk` from `sys_clk` in three behaviours: continuous run, single micro-step, and whole-instruction step. It takes a raw, bouncy step button and the CPU halt line, and guarantees glitch-free pulses of fixed width across mode changes. It sits between the board I/O (switch, button) and every `cpu_clk` consumer, including the control unit, registers and RAM.

## Interface
- `HALF_PERIOD`, default 4: `sys_clk` cycles per `cpu_clk` high phase and per low phase (≥1).
- `DEBOUNCE`, default 16: consecutive stable synchronised samples needed to accept a button level change (≥1).
- `STEPS`, default 5: micro-steps per instruction (≥2).
- `sys_clk  input  1`: system clock, only clock.
- `rst  input  1`: asynchronous, active-high reset.
- `mode  input  1`: 0 = continuous, 1 = manual.
- `instr_step  input  1`: manual only; 0 = one pulse per press, 1 = run to instruction boundary.
- `step_btn  input  1`: raw asynchronous button, active-high.
- `halt  input  1`: CPU HLT, synchronous to `sys_clk`.
- `cpu_clk  output  1`: generated CPU clock.
- `clk_rise  output  1`: one-`sys_clk` pulse in the first cycle of each `cpu_clk` high phase.
- `micro  output  $clog2(STEPS)`: micro-step index, counted modulo `STEPS`.
- `halted  output  1`: sticky halt indicator.
- `busy  output  1`: high in every state except STOP.

## Operation
- Button path: 2-flop synchroniser, then debounce counter. The debounced level changes only after `DEBOUNCE` consecutive synchronised samples differ from it. A debounced 0→1 edge is a step request for one cycle. It is never queued.
- FSM states: STOP, RUN_HI, RUN_LO, STEP_HI, STEP_LO.
- `cpu_clk` = 1 exactly in RUN_HI and STEP_HI. It is driven from a register, so it is glitch-free.
- Phase timer: reloads on every state entry. Every HI/LO state lasts exactly `HALF_PERIOD` cycles.
- From STOP:
  - If `halted`, stay in STOP.
  - Else if `mode`=0, go to RUN_HI.
  - Else if a step request is present, go to STEP_HI.
  - Otherwise stay in STOP.
- RUN_HI → RUN_LO at timer end.
- At end of RUN_LO:
  - If halt is pending or `mode`=1, go to STOP.
  - Otherwise go to RUN_HI.
- STEP_HI → STEP_LO at timer end.
- At end of STEP_LO:
  - If halt is pending, go to STOP.
  - Else if `instr_step`=1 and `micro`≠0, go to STEP_HI.
  - Otherwise go to STOP.
- `micro` increments on every entry into RUN_HI or STEP_HI, in the same cycle as `clk_rise`. It wraps from `STEPS`-1 to 0.
- Halt:
  - `halt` high in any cycle sets the halt-pending flag.
  - The current pulse always completes its full high and low phases.
  - Entering STOP with halt pending sets `halted`. `halted` is cleared only by `rst`.
- Mode change is sampled only at the end of a low phase or in STOP. A high phase is never shortened.
- Step requests are dropped in these cases:
  - `mode`=0.
  - Any non-STOP state.
  - `halted`=1.

## Timing
- Reset values, asserted asynchronously:
  - state = STOP, timer = 0, `micro` = 0.
  - `cpu_clk`, `clk_rise`, `halted`, `busy`, halt-pending = 0.
  - Synchroniser and debounced level = 0.
- Continuous `cpu_clk` period is 2·`HALF_PERIOD` `sys_clk` cycles at 50% duty.
- After reset release with `mode`=0, `cpu_clk` rises on the 1st `sys_clk` edge.
- Button latency, from the first stable raw sample to `cpu_clk` rising: 2 cycles (synchroniser) + `DEBOUNCE` + 1 (STOP→STEP_HI).
- Instruction step from `micro`=k issues (`STEPS`-k) mod `STEPS` pulses. If that count is 0, it issues `STEPS` pulses, back-to-back with no gap.
- `halt` asserted during RUN_HI: the current pulse finishes, then STOP. `halted` rises in the same cycle STOP is entered.
- `rst` mid-pulse: `cpu_clk` drops immediately, with no minimum-width guarantee.

## Test plan
Parameters for all scenarios: `HALF_PERIOD`=2, `DEBOUNCE`=4, `STEPS`=5.
- **Continuous run.** Stimulus: reset, `mode`=0, 40 cycles. Required: `cpu_clk` period 4 with high for 2 cycles, 10 `clk_rise` pulses, `micro` sequence 1,2,3,4,0,1…, `busy`=1.
- **Bouncy button.** Stimulus: `mode`=1, `instr_step`=0; button toggles every 2 cycles for 12 cycles, then held high 10 cycles, then released. Required: exactly one `cpu_clk` pulse (2 high, 2 low), `micro` 0→1, then STOP with `busy`=0.
- **Instruction step.** Stimulus: `mode`=1, `instr_step`=1, `micro`=2, one clean press. Required: 3 contiguous pulses, `micro` 3,4,0, then STOP. A second press gives 5 pulses ending at `micro`=0.
- **Halt.** Stimulus: `mode`=0; `halt` pulsed for 1 cycle in the 1st cycle of RUN_HI. Required: that pulse completes its 2 high + 2 low cycles, then STOP with `halted`=1. Subsequent button presses and `mode` toggles produce no `cpu_clk`.
- **Mode switch mid-high.** Stimulus: `mode` 0→1 in the 1st cycle of RUN_HI. Required: high lasts the full 2 cycles, low lasts 2, then STOP. A press issues one pulse, and no pulse is shorter than 2 cycles.
- **Reset mid-sequence.** Stimulus: `rst` asserted in the middle of an instruction step at `micro`=3. Required: immediately `cpu_clk`=0, `micro`=0, `busy`=0, `halted`=0. After release with `mode`=1, no pulse until a new press.
